// File: rtl/ahbl_to_apb.sv
// AHB-Lite responder bridging each AHB transfer to a single APB transfer.
// Optional APB4 pprot/pstrb outputs enabled by defining AHBL_TO_APB_APB4_EN.
module ahbl_to_apb #(
  parameter int unsigned W_HADDR = 32,
  parameter int unsigned W_PADDR = 16,
  parameter int unsigned W_DATA  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ahbls_hready,
  output logic                 ahbls_hready_resp,
  output logic                 ahbls_hresp,
  output logic                 ahbls_hexokay,
  input  logic [W_HADDR-1:0]   ahbls_haddr,
  input  logic                 ahbls_hwrite,
  input  logic [1:0]           ahbls_htrans,
  input  logic [2:0]           ahbls_hsize,
  input  logic [2:0]           ahbls_hburst,
  input  logic [3:0]           ahbls_hprot,
  input  logic                 ahbls_hmastlock,
  input  logic                 ahbls_hexcl,
  input  logic [W_DATA-1:0]    ahbls_hwdata,
  output logic [W_DATA-1:0]    ahbls_hrdata,
  output logic [W_PADDR-1:0]   apbm_paddr,
  output logic                 apbm_psel,
  output logic                 apbm_penable,
  output logic                 apbm_pwrite,
  output logic [W_DATA-1:0]    apbm_pwdata,
  input  logic [W_DATA-1:0]    apbm_prdata,
  input  logic                 apbm_pready,
`ifdef AHBL_TO_APB_APB4_EN
  output logic [2:0]           apbm_pprot,
  output logic [W_DATA/8-1:0]  apbm_pstrb,
`endif
  input  logic                 apbm_pslverr
);

  localparam int unsigned W_STRB = W_DATA / 8;
  localparam int unsigned W_OFF  = $clog2(W_STRB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state;
  logic   accept_c;
  logic   done_ok_c;
  logic   load_c;

  // A new address phase may land in IDLE, ERR2, or on a clean ACCESS completion
  assign accept_c  = ahbls_hready && ahbls_htrans[1];
  assign done_ok_c = (state == S_ACCESS) && apbm_pready && !apbm_pslverr;
  assign load_c    = accept_c && ((state == S_IDLE) || (state == S_ERR2) || done_ok_c);

`ifdef AHBL_TO_APB_APB4_EN
  logic [W_STRB-1:0] pstrb_c;
  int unsigned       nbytes;
  int unsigned       offset;

  // Byte lanes touched by the transfer; lanes beyond the bus width drop off
  always_comb begin
    pstrb_c = '0;
    nbytes  = 32'(1) << ahbls_hsize;
    offset  = 32'(ahbls_haddr[W_OFF-1:0]);
    for (int unsigned i = 0; i < W_STRB; i++) begin
      pstrb_c[i] = ahbls_hwrite && (i >= offset) && (i < offset + nbytes);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      apbm_paddr  <= '0;
      apbm_pwrite <= 1'b0;
`ifdef AHBL_TO_APB_APB4_EN
      apbm_pprot  <= '0;
      apbm_pstrb  <= '0;
`endif
    end else begin
      if (load_c) begin
        apbm_paddr  <= ahbls_haddr[W_PADDR-1:0];
        apbm_pwrite <= ahbls_hwrite;
`ifdef AHBL_TO_APB_APB4_EN
        apbm_pprot  <= {~ahbls_hprot[0], 1'b1, ahbls_hprot[1]};
        apbm_pstrb  <= pstrb_c;
`endif
      end
      case (state)
        S_IDLE, S_ERR2: state <= load_c ? S_SETUP : S_IDLE;
        S_SETUP:        state <= S_ACCESS;
        S_ACCESS: begin
          if (apbm_pready) begin
            if (apbm_pslverr) state <= S_ERR1;
            else              state <= load_c ? S_SETUP : S_IDLE;
          end
        end
        S_ERR1:         state <= S_ERR2;
        default:        state <= S_IDLE;
      endcase
    end
  end

  assign apbm_psel    = (state == S_SETUP) || (state == S_ACCESS);
  assign apbm_penable = (state == S_ACCESS);

  // AHB response follows the APB handshake in ACCESS without an extra cycle
  always_comb begin
    ahbls_hready_resp = 1'b1;
    ahbls_hresp       = 1'b0;
    case (state)
      S_SETUP: ahbls_hready_resp = 1'b0;
      S_ACCESS: begin
        ahbls_hready_resp = apbm_pready && !apbm_pslverr;
        ahbls_hresp       = apbm_pready && apbm_pslverr;
      end
      S_ERR1: begin
        ahbls_hready_resp = 1'b0;
        ahbls_hresp       = 1'b1;
      end
      S_ERR2:  ahbls_hresp = 1'b1;
      default: ;
    endcase
  end

  assign ahbls_hexokay = 1'b0;
  assign apbm_pwdata   = (apbm_pwrite && apbm_psel) ? ahbls_hwdata : '0;
  assign ahbls_hrdata  = ((state == S_ACCESS) && !apbm_pwrite) ? apbm_prdata : '0;

  logic unused;
`ifdef AHBL_TO_APB_APB4_EN
  assign unused = ^{ahbls_hburst, ahbls_hmastlock, ahbls_hexcl, ahbls_htrans[0],
                    ahbls_haddr[W_HADDR-1:W_PADDR], ahbls_hprot[3:2]};
`else
  assign unused = ^{ahbls_hburst, ahbls_hmastlock, ahbls_hexcl, ahbls_htrans[0],
                    ahbls_haddr[W_HADDR-1:W_PADDR], ahbls_hprot, ahbls_hsize};
`endif

endmodule
